btn_cmd_arbiter: RTL and testbench

Collects debounced push-button levels from the board's debouncer instances and converts presses into single command tokens for the inference-control FSM (start, next image, clear, and so on). Detects press edges, adds hold-to-repeat, and arbitrates simultaneous presses round-robin. Presents one command at a time on a valid/ready handshake. Sits between the per-button debouncers and the top-level control logic.

---
 rtl/btn_cmd_arbiter.sv | 82 ++++++++
 tb/tb_btn_cmd_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: turns debounced button levels into single command tokens with press-edge
// detection, hold-to-repeat and round-robin arbitration, offered on a valid/ready handshake.
module btn_cmd_arbiter #(
    parameter int N_BTN = 5,
    parameter int HOLD_CYCLES = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W = 26,
    localparam int IDX_W = $clog2(N_BTN)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn,
    input  logic             i_repeat_en,
    output logic             o_cmd_valid,
    output logic [IDX_W-1:0] o_cmd_id,
    input  logic             i_cmd_ready,
    output logic             o_drop,
    output logic             o_busy
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, state_d;
    logic [N_BTN-1:0] btn_q, pending, rise, rep_tick, ev, clear_mask;
    logic [CNT_W-1:0] cnt;
    logic rep_phase, active, fire, found;
    logic [IDX_W-1:0] rr_ptr, rr_d, id_d, pick;

    assign rise = i_btn & ~btn_q;
    // repeat only runs while exactly one button is held steadily
    assign active = i_repeat_en && $onehot(btn_q) && i_btn == btn_q;
    assign fire = active && cnt == (rep_phase ? CNT_W'(REPEAT_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1));
    assign rep_tick = fire ? btn_q : '0;
    assign ev = rise | rep_tick;
    assign clear_mask = (state == OFFER && i_cmd_ready) ? N_BTN'(1) << o_cmd_id : '0;
    assign o_cmd_valid = state == OFFER;
    assign o_busy = |pending | o_cmd_valid;

    always_comb begin
        pick = '0;
        found = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!found && pending[IDX_W'((int'(rr_ptr) + k) % N_BTN)]) begin
                found = 1'b1;
                pick = IDX_W'((int'(rr_ptr) + k) % N_BTN);
            end
        end
    end

    always_comb begin
        state_d = state;
        id_d = o_cmd_id;
        rr_d = rr_ptr;
        if (state == IDLE && |pending) begin
            state_d = OFFER;
            id_d = pick;
        end else if (state == OFFER && i_cmd_ready) begin
            state_d = IDLE;
            rr_d = o_cmd_id == IDX_W'(N_BTN - 1) ? '0 : o_cmd_id + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            btn_q <= '0;
            pending <= '0;
            cnt <= '0;
            rep_phase <= 1'b0;
            rr_ptr <= '0;
            o_cmd_id <= '0;
            o_drop <= 1'b0;
        end else begin
            state <= state_d;
            btn_q <= i_btn;
            pending <= (pending & ~clear_mask) | ev;
            o_drop <= |(ev & pending & ~clear_mask);
            cnt <= (!active || fire) ? '0 : cnt + 1'b1;
            rep_phase <= active && (rep_phase || fire);
            rr_ptr <= rr_d;
            o_cmd_id <= id_d;
        end
    end
endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// tb_btn_cmd_arbiter: cycle-by-cycle vector table for btn_cmd_arbiter plus hold/repeat sequences.
module tb_btn_cmd_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic repeat_en = 1'b0;
    logic cmd_ready = 1'b1;
    logic [3:0] btn = '0;
    logic cmd_valid, drop, busy;
    logic [1:0] cmd_id;
    int checks = 0;
    int failures = 0;

    btn_cmd_arbiter #(.N_BTN(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_btn(btn),
        .i_repeat_en(repeat_en),
        .o_cmd_valid(cmd_valid),
        .o_cmd_id(cmd_id),
        .i_cmd_ready(cmd_ready),
        .o_drop(drop),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n;
        logic [3:0] btn;
        logic rdy;
        logic valid;
        logic [1:0] id;
        logic drop;
        logic busy;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] b, input logic rd, input logic v,
                       input logic [1:0] i, input logic d, input logic bs);
        vec_t x;
        x.rst_n = r;
        x.btn = b;
        x.rdy = rd;
        x.valid = v;
        x.id = i;
        x.drop = d;
        x.busy = bs;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Button b is driven for edges 1..30, released for 31..40; exp_v bit n = valid after edge n.
    task automatic hold_run(input string name, input logic [3:0] b, input logic rep,
                            input logic [63:0] exp_v, input int exp_tok, input int exp_id);
        int tok = 0;
        repeat_en = rep;
        cmd_ready = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            btn = (n <= 30) ? b : 4'b0000;
            tick();
            check($sformatf("%s valid@%0d", name, n), cmd_valid, exp_v[n]);
            check($sformatf("%s drop@%0d", name, n), drop, 0);
            if (cmd_valid) begin
                tok++;
                if (exp_id >= 0) check($sformatf("%s id@%0d", name, n), cmd_id, exp_id);
            end
        end
        check($sformatf("%s tokens", name), tok, exp_tok);
        check($sformatf("%s busy_end", name), busy, 0);
    endtask

    initial begin
        logic [63:0] m_rep, m_one, m_two;
        // reset state
        add(0, 4'b0000, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 0);
        // simultaneous 1011 from rr_ptr=0: ids 0,1,3
        add(1, 4'b1011, 1, 0, 0, 0, 1);
        add(1, 4'b0000, 1, 1, 0, 0, 1);
        add(1, 4'b0000, 1, 0, 0, 0, 1);
        add(1, 4'b0000, 1, 1, 1, 0, 1);
        add(1, 4'b0000, 1, 0, 1, 0, 1);
        add(1, 4'b0000, 1, 1, 3, 0, 1);
        add(1, 4'b0000, 1, 0, 3, 0, 0);
        add(1, 4'b0000, 1, 0, 3, 0, 0);
        // single press of bit 0 held three cycles
        add(1, 4'b0001, 1, 0, 3, 0, 1);
        add(1, 4'b0001, 1, 1, 0, 0, 1);
        add(1, 4'b0001, 1, 0, 0, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 0);
        // grant id 1, then 0101 goes 2 then wraps to 0
        add(1, 4'b0010, 1, 0, 0, 0, 1);
        add(1, 4'b0000, 1, 1, 1, 0, 1);
        add(1, 4'b0000, 1, 0, 1, 0, 0);
        add(1, 4'b0101, 1, 0, 1, 0, 1);
        add(1, 4'b0000, 1, 1, 2, 0, 1);
        add(1, 4'b0000, 1, 0, 2, 0, 1);
        add(1, 4'b0000, 1, 1, 0, 0, 1);
        add(1, 4'b0000, 1, 0, 0, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 0);
        // backpressure, second press of bit 2 merges and pulses drop
        add(1, 4'b0100, 0, 0, 0, 0, 1);
        add(1, 4'b0000, 0, 1, 2, 0, 1);
        add(1, 4'b0100, 0, 1, 2, 1, 1);
        add(1, 4'b0000, 0, 1, 2, 0, 1);
        add(1, 4'b0000, 1, 0, 2, 0, 0);
        add(1, 4'b0000, 1, 0, 2, 0, 0);
        // new press on the bit being accepted: set wins, no drop
        add(1, 4'b0100, 0, 0, 2, 0, 1);
        add(1, 4'b0000, 0, 1, 2, 0, 1);
        add(1, 4'b0100, 1, 0, 2, 0, 1);
        add(1, 4'b0000, 1, 1, 2, 0, 1);
        add(1, 4'b0000, 1, 0, 2, 0, 0);
        // reset mid-offer with another bit pending
        add(1, 4'b0110, 0, 0, 2, 0, 1);
        add(1, 4'b0000, 0, 1, 1, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 0);
        add(1, 4'b0100, 1, 0, 0, 0, 1);
        add(1, 4'b0000, 1, 1, 2, 0, 1);
        add(1, 4'b0000, 1, 0, 2, 0, 0);

        foreach (vecs[k]) begin
            rst_n = vecs[k].rst_n;
            btn = vecs[k].btn;
            cmd_ready = vecs[k].rdy;
            tick();
            check($sformatf("v%0d valid", k), cmd_valid, vecs[k].valid);
            check($sformatf("v%0d id", k), cmd_id, vecs[k].id);
            check($sformatf("v%0d drop", k), drop, vecs[k].drop);
            check($sformatf("v%0d busy", k), busy, vecs[k].busy);
        end

        m_rep = '0;
        m_rep[2] = 1'b1;
        for (int e = 10; e <= 30; e += 4) m_rep[e] = 1'b1;
        m_one = '0;
        m_one[2] = 1'b1;
        m_two = m_one;
        m_two[4] = 1'b1;
        hold_run("rep", 4'b0010, 1'b1, m_rep, 7, 1);
        hold_run("norep", 4'b0010, 1'b0, m_one, 1, 1);
        hold_run("two", 4'b1010, 1'b1, m_two, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
